// File: rtl/uart_rx.sv
// UART receiver: 2-FF input synchronizer, mid-bit sampling from an internal divider,
// LSB-first framing with one start and one stop bit, framing-error and break handling.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RX_in,
  output logic [DATA_BITS-1:0] RX_data,
  output logic                 RX_valid,
  output logic                 RX_err,
  output logic                 RX_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [CW-1:0]        r_clk_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 w_shift;
  logic                 w_valid_set;
  logic                 w_err_set;

  // Synchronizer presets to the idle (high) level so reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RX_in;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_valid_set = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE:
        if (!r_rx_s) w_state_nxt = S_START;
      S_START:
        if (r_clk_cnt == CNT_HALF) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (r_clk_cnt == CNT_LAST) begin
          w_shift = 1'b1;
          if (r_bit_cnt == BITS_LAST) w_state_nxt = S_STOP;
        end
      S_STOP:
        // Leaving at mid-stop gives half a bit of slack to catch a back-to-back start
        if (r_clk_cnt == CNT_LAST) begin
          if (r_rx_s) begin
            w_valid_set = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_err_set   = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      S_BREAK:
        if (r_rx_s) w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      if ((w_state_nxt != r_state) || (r_state == S_IDLE) || (r_state == S_BREAK) ||
          ((r_state == S_DATA) && (r_clk_cnt == CNT_LAST)))
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + CW'(1);
      if (r_state == S_START)
        r_bit_cnt <= '0;
      else if (w_shift)
        r_bit_cnt <= r_bit_cnt + BW'(1);
    end
  end

  // Shift right so the first (LSB) bit ends up at bit 0 after DATA_BITS samples
  always_ff @(posedge clk) begin
    if (w_shift) r_shreg <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RX_data  <= '0;
      RX_valid <= 1'b0;
      RX_err   <= 1'b0;
    end else begin
      RX_valid <= w_valid_set;
      RX_err   <= w_err_set;
      if (w_valid_set) RX_data <= r_shreg;
    end
  end

  assign RX_busy = (r_state != S_IDLE);

endmodule
